// File: rtl/mandelbrot_pixel_gen.sv
// Raster coordinate generator: walks an IMG_W x IMG_H frame row-major, emitting c = (c_re, c_im).
// Optional abort input enabled by defining MANDELBROT_PIXGEN_ABORT_EN.
module mandelbrot_pixel_gen #(
  parameter int unsigned DW    = 32,
  parameter int unsigned IMG_W = 640,
  parameter int unsigned IMG_H = 480,
  parameter int unsigned COL_W = 10,
  parameter int unsigned ROW_W = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [DW-1:0]    x0,
  input  logic [DW-1:0]    y0,
  input  logic [DW-1:0]    dx,
  input  logic [DW-1:0]    dy,
`ifdef MANDELBROT_PIXGEN_ABORT_EN
  input  logic             abort,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    c_re,
  output logic [DW-1:0]    c_im,
  output logic [COL_W-1:0] col,
  output logic [ROW_W-1:0] row,
  output logic             last,
  output logic             busy,
  output logic             done
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  localparam logic [COL_W-1:0] ColLast = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] RowLast = ROW_W'(IMG_H - 1);

  state_e           state_q, state_d;
  logic [DW-1:0]    x0_q, x0_d;
  logic [DW-1:0]    dx_q, dx_d;
  logic [DW-1:0]    dy_q, dy_d;
  logic [DW-1:0]    c_re_q, c_re_d;
  logic [DW-1:0]    c_im_q, c_im_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             done_q, done_d;
  logic             abort_req;

`ifdef MANDELBROT_PIXGEN_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    x0_d    = x0_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    c_re_d  = c_re_q;
    c_im_d  = c_im_q;
    col_d   = col_q;
    row_d   = row_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        // An abort coinciding with start keeps the block idle.
        if (start && !abort_req) begin
          x0_d    = x0;
          dx_d    = dx;
          dy_d    = dy;
          c_re_d  = x0;
          c_im_d  = y0;
          col_d   = '0;
          row_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        if (abort_req) begin
          state_d = StIdle;
        end else if (out_ready) begin
          if (col_q != ColLast) begin
            col_d  = col_q + COL_W'(1);
            c_re_d = c_re_q + dx_q;
          end else if (row_q != RowLast) begin
            col_d  = '0;
            c_re_d = x0_q;
            row_d  = row_q + ROW_W'(1);
            c_im_d = c_im_q + dy_q;
          end else begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      x0_q    <= '0;
      dx_q    <= '0;
      dy_q    <= '0;
      c_re_q  <= '0;
      c_im_q  <= '0;
      col_q   <= '0;
      row_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x0_q    <= x0_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      c_re_q  <= c_re_d;
      c_im_q  <= c_im_d;
      col_q   <= col_d;
      row_q   <= row_d;
      done_q  <= done_d;
    end
  end

  assign out_valid = (state_q == StRun);
  assign busy      = (state_q == StRun);
  assign done      = done_q;
  assign c_re      = c_re_q;
  assign c_im      = c_im_q;
  assign col       = col_q;
  assign row       = row_q;
  assign last      = (state_q == StRun) && (col_q == ColLast) && (row_q == RowLast);

endmodule

// File: tb/tb_mandelbrot_pixel_gen.sv
// Bench for mandelbrot_pixel_gen on a 4x3 frame; abort checks only with MANDELBROT_PIXGEN_ABORT_EN.
module tb_mandelbrot_pixel_gen;

  localparam int W    = 4;
  localparam int H    = 3;
  localparam int NPIX = W * H;

  typedef struct {
    logic [31:0] x0;
    logic [31:0] y0;
    logic [31:0] dx;
    logic [31:0] dy;
    logic [31:0] exp_re1;
    logic [31:0] exp_im_last;
  } frame_t;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] x0, y0, dx, dy;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] c_re, c_im;
  logic [1:0]  col, row;
  logic        last, busy, done;
`ifdef MANDELBROT_PIXGEN_ABORT_EN
  logic        abort;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  mandelbrot_pixel_gen #(
    .DW   (32),
    .IMG_W(W),
    .IMG_H(H),
    .COL_W(2),
    .ROW_W(2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .x0       (x0),
    .y0       (y0),
    .dx       (dx),
    .dy       (dy),
`ifdef MANDELBROT_PIXGEN_ABORT_EN
    .abort    (abort),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .c_re     (c_re),
    .c_im     (c_im),
    .col      (col),
    .row      (row),
    .last     (last),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: pixel k sits at (k mod W, k div W); c is base + index * step, mod 2^32.
  function automatic logic [31:0] exp_re(input frame_t f, input int k);
    return f.x0 + 32'(k % W) * f.dx;
  endfunction

  function automatic logic [31:0] exp_im(input frame_t f, input int k);
    return f.y0 + 32'(k / W) * f.dy;
  endfunction

  task automatic issue_start(input frame_t f);
    x0 = f.x0; y0 = f.y0; dx = f.dx; dy = f.dy;
    start = 1'b1;
    step();
    start = 1'b0;
    x0 = $urandom; y0 = $urandom; dx = $urandom; dy = $urandom;
  endtask

  // Drains one frame; returns positioned in the cycle after the final handshake.
  task automatic run_words(input frame_t f, input int mode,
                           output logic [31:0] re1, output logic [31:0] im_last);
    int   k   = 0;
    int   cyc = 0;
    logic rdy;
    re1 = '0;
    im_last = '0;
    while (k < NPIX && cyc < 200) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 3 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      out_ready = rdy;
      // Start and parameter changes during RUN must be ignored.
      start = 1'($urandom_range(0, 1));
      x0 = $urandom; y0 = $urandom; dx = $urandom; dy = $urandom;
      chk("valid", out_valid, 1);
      chk("busy", busy, 1);
      chk("done_low", done, 0);
      chk("col", col, 64'(k % W));
      chk("row", row, 64'(k / W));
      chk("c_re", c_re, exp_re(f, k));
      chk("c_im", c_im, exp_im(f, k));
      chk("last", last, (k == NPIX - 1));
      if (rdy) begin
        if (k == 1) re1 = c_re;
        if (k == NPIX - 1) im_last = c_im;
        k++;
      end
      step();
      cyc++;
    end
    start = 1'b0;
    out_ready = 1'b0;
    if (k < NPIX) begin
      n_checks++;
      n_fail++;
      $display("FAIL frame_timeout: got %0d words required %0d", k, NPIX);
    end
    chk("done_pulse", done, 1);
    chk("busy_fall", busy, 0);
    chk("valid_fall", out_valid, 0);
  endtask

  frame_t      vec[6];
  logic [31:0] re1, iml;

  initial begin
    rst_n = 1'b0; start = 1'b0; out_ready = 1'b0;
    x0 = '0; y0 = '0; dx = '0; dy = '0;
`ifdef MANDELBROT_PIXGEN_ABORT_EN
    abort = 1'b0;
`endif
    vec[0] = '{32'h1000, 32'h2000, 32'h10, 32'h20, 32'h1010, 32'h2040};
    vec[1] = '{32'h7FFFFFF0, 32'h0, 32'h10, 32'h0, 32'h80000000, 32'h0};
    vec[2] = '{32'h0, 32'h0, 32'hFFFFFFF0, 32'h1, 32'hFFFFFFF0, 32'h2};
    for (int i = 3; i < 6; i++) begin
      vec[i].x0 = $urandom; vec[i].y0 = $urandom;
      vec[i].dx = $urandom; vec[i].dy = $urandom;
      vec[i].exp_re1 = exp_re(vec[i], 1);
      vec[i].exp_im_last = exp_im(vec[i], NPIX - 1);
    end

    step();
    step();
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_c_re", c_re, 0);
    chk("rst_c_im", c_im, 0);
    chk("rst_col", col, 0);
    chk("rst_row", row, 0);
    chk("rst_last", last, 0);
    rst_n = 1'b1;
    step();
    chk("idle_valid", out_valid, 0);

    for (int i = 0; i < 6; i++) begin
      issue_start(vec[i]);
      run_words(vec[i], i % 3, re1, iml);
      chk("tbl_re1", re1, vec[i].exp_re1);
      chk("tbl_im_last", iml, vec[i].exp_im_last);
      step();
      chk("done_one_cycle", done, 0);
      chk("idle_after", out_valid, 0);
    end

    // Back-to-back: start in the done cycle is accepted.
    issue_start(vec[0]);
    run_words(vec[0], 0, re1, iml);
    issue_start(vec[3]);
    run_words(vec[3], 2, re1, iml);
    step();
    chk("b2b_done_low", done, 0);

    // Reset mid-frame after five words.
    issue_start(vec[0]);
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk("pre_rst_col", col, 64'(k % W));
      step();
    end
    out_ready = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_c_re", c_re, 0);
    chk("mid_rst_c_im", c_im, 0);
    chk("mid_rst_col", col, 0);
    chk("mid_rst_row", row, 0);
    chk("mid_rst_done", done, 0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("post_rst_done", done, 0);
      chk("post_rst_valid", out_valid, 0);
    end

`ifdef MANDELBROT_PIXGEN_ABORT_EN
    issue_start(vec[0]);
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) step();
    chk("pre_abort_col", col, 2);
    abort = 1'b1;
    step();
    abort = 1'b0;
    out_ready = 1'b0;
    chk("abort_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    // Abort with start in IDLE stays idle.
    abort = 1'b1;
    issue_start(vec[1]);
    abort = 1'b0;
    chk("abort_start_idle", out_valid, 0);
    issue_start(vec[1]);
    chk("restart_col", col, 0);
    chk("restart_row", row, 0);
    chk("restart_c_re", c_re, vec[1].x0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mandelbrot_pixel_gen.md
# mandelbrot_pixel_gen

Raster coordinate generator at the input end of the Mandelbrot compute pipeline. On a start pulse it walks an IMG_W × IMG_H frame in row-major order. For each pixel it issues the signed fixed-point point c = (c_re, c_im) plus the pixel's column and row through a valid/ready handshake. The first `mandelbrot_compute_*` stage consumes these values as its x/y inputs.

## Interface
- DW, 32: width of fixed-point coordinate words (two's complement, any Q format; the block only adds).
- IMG_W, 640: pixels per row; 1 ≤ IMG_W ≤ 2^COL_W.
- IMG_H, 480: rows per frame; 1 ≤ IMG_H ≤ 2^ROW_W.
- COL_W, 10: width of col output.
- ROW_W, 9: width of row output.

- clk  in  1  sole clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  single-cycle request to begin a frame; sampled only in IDLE.
- x0  in  DW  c_re of column 0; latched on accepted start.
- y0  in  DW  c_im of row 0; latched on accepted start.
- dx  in  DW  c_re increment per column; latched on accepted start.
- dy  in  DW  c_im increment per row; latched on accepted start.
- out_valid  out  1  pixel word present.
- out_ready  in  1  downstream accepts the word this cycle.
- c_re  out  DW  real part of the current pixel.
- c_im  out  DW  imaginary part of the current pixel.
- col  out  COL_W  current column, 0..IMG_W-1.
- row  out  ROW_W  current row, 0..IMG_H-1.
- last  out  1  high with the final pixel of the frame (col = IMG_W-1, row = IMG_H-1).
- busy  out  1  high from accepted start until after the final handshake.
- done  out  1  one-cycle pulse after the final handshake.

## Operation
- Two states: IDLE and RUN.
- **IDLE.** out_valid = 0 and busy = 0. On start = 1:
  - latch x0, y0, dx, dy;
  - load col = 0, row = 0, c_re = x0, c_im = y0;
  - go to RUN.
- **RUN.** out_valid = 1 and busy = 1. A handshake is out_valid & out_ready. On each handshake:
  - if col < IMG_W-1: col += 1, c_re += dx_l.
  - else, if row < IMG_H-1: col = 0, c_re = x0_l, row += 1, c_im += dy_l.
  - else (last pixel): go to IDLE and pulse done.
- **No handshake.** While out_valid is high and out_ready is low, all outputs hold stable.
- **Arithmetic.** Additions are DW-bit modulo 2^DW; wrap is silent, with no saturation and no flag.
- **Accumulation.** c_re/c_im are accumulated, never multiplied. After k steps, c_re = x0 + k·dx mod 2^DW exactly.
- **start in RUN** is ignored. Latched parameters are unaffected by later changes on x0/y0/dx/dy.
- **last** is combinational from col/row/state, or registered to the same value.
- **Degenerate sizes.** With IMG_W = IMG_H = 1, the frame is exactly one word with last = 1.
- **Reset.** rst_n = 0 at a clock edge forces IDLE from any state, including mid-frame; the partial frame is abandoned. Reset values:
  - out_valid = 0, busy = 0, done = 0;
  - c_re = 0, c_im = 0, col = 0, row = 0;
  - last = 0 and latched parameters = 0.

## Timing
- start accepted at edge N → out_valid = 1 at N+1 carrying pixel (0,0).
- Throughput is one pixel per cycle while out_ready = 1, so a full frame takes IMG_W·IMG_H cycles plus 1 cycle start latency.
- Final handshake at edge M → out_valid = 0, busy = 0, done = 1 during cycle M+1.
- done lasts exactly one cycle.
- A start in cycle M+1 is accepted, so back-to-back frames have one idle cycle.
- All outputs are registered except optionally last; there is no combinational path from out_ready to out_valid.

## Configuration
- **MANDELBROT_PIXGEN_ABORT_EN defined:** adds input abort (1 bit).
  - abort = 1 in RUN returns the block to IDLE at the next edge.
  - Effect: out_valid = 0, busy = 0, and done stays 0 (no pulse).
  - abort has priority over a simultaneous handshake; that word counts as not delivered.
  - abort in IDLE has no effect, and abort with start in IDLE leaves the block in IDLE.
- **Not defined:** no abort port. A frame ends only by completion or reset.

## Test plan
Directed scenarios use IMG_W = 4, IMG_H = 3, DW = 32.

- **Full frame, ready held high.** Stimulus: x0 = 0x1000, y0 = 0x2000, dx = 0x10, dy = 0x20, start, out_ready = 1. Required response:
  - 12 words, (col,row) = (0,0)..(3,2) in row-major order;
  - c_re sequence 0x1000, 0x1010, 0x1020, 0x1030, repeating per row;
  - c_im = 0x2000, 0x2020, 0x2040 per row;
  - last only on word 12;
  - done one cycle after word 12, and busy falls in that same cycle.
- **Backpressure.** Toggle out_ready 1,0,0,1,… → outputs are stable during every stall, there are no duplicate or skipped words, and all 12 words arrive in order.
- **Wrap-around and negative step.**
  - x0 = 0x7FFFFFF0, dx = 0x10 → word 2 has c_re = 0x80000000.
  - dx = 0xFFFFFFF0 (negative), x0 = 0 → c_re = 0, 0xFFFFFFF0, 0xFFFFFFE0, 0xFFFFFFD0.
- **Start handling.**
  - start pulsed again mid-frame with different x0 → ignored; the frame completes with the original values.
  - start in the done cycle → a new frame is accepted, with pixel (0,0) at the next edge.
- **Reset mid-frame.** rst_n = 0 after word 5 → out_valid = 0, busy = 0, c_re = c_im = 0 and col = row = 0 at the following edge. done is never pulsed.
- **Abort (MANDELBROT_PIXGEN_ABORT_EN defined).** Assert abort together with the handshake of word 7 → the next cycle has out_valid = 0, busy = 0, done = 0, and a following start restarts at (0,0).
